mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_if.sv | 25 ++
 rtl/mc_ctrl.sv | 91 +++++++++
 tb/tb_mc_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: opcode/status inputs and control strobes between the multicycle controller and its datapath
interface mc_ctrl_if #(parameter int OP_W = 6);
  logic [OP_W-1:0] iOpcode;
  logic [OP_W-1:0] iFunct;
  logic            iMemReady;
  logic            iAluZero;
  logic            oIR_en;
  logic            oMDR_en;
  logic            oRF_Write;
  logic            oPC_en;
  logic            oMemRead;
  logic            oMemWrite;
  logic            oAddrSel;
  logic [OP_W-1:0] oALU_op;
  logic            oHalt;
  logic            oFault;
  modport master (
    output iOpcode, iFunct, iMemReady, iAluZero,
    input  oIR_en, oMDR_en, oRF_Write, oPC_en, oMemRead, oMemWrite, oAddrSel, oALU_op, oHalt, oFault
  );
  modport slave (
    input  iOpcode, iFunct, iMemReady, iAluZero,
    output oIR_en, oMDR_en, oRF_Write, oPC_en, oMemRead, oMemWrite, oAddrSel, oALU_op, oHalt, oFault
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle CPU control FSM with memory wait timeout, sticky halt and fault
module mc_ctrl #(
  parameter int OP_W        = 6,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic     iClk,
  input  logic     nRst,
  mc_ctrl_if.slave bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT} state_t;
  localparam logic [OP_W-1:0] OP_R    = '0;
  localparam logic [OP_W-1:0] OP_LW   = OP_W'('h23);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'('h2B);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'('h04);
  localparam logic [OP_W-1:0] OP_HLT  = OP_W'('h3F);
  localparam logic [OP_W-1:0] ALU_ADD = OP_W'('h20);
  localparam logic [OP_W-1:0] ALU_SUB = OP_W'('h22);
  // the fault fires on the wait cycle that carries the counter to MEM_TIMEOUT
  localparam logic [7:0]      WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  state_t     r_state;
  state_t     w_next;
  logic       r_run;
  logic [7:0] r_wait;
  logic       w_r;
  logic       w_ld;
  logic       w_st;
  logic       w_beq;
  logic       w_hlt;
  logic       w_req;
  logic       w_timeout;
  assign w_r       = bus.iOpcode == OP_R;
  assign w_ld      = bus.iOpcode == OP_LW;
  assign w_st      = bus.iOpcode == OP_SW;
  assign w_beq     = bus.iOpcode == OP_BEQ;
  assign w_hlt     = bus.iOpcode == OP_HLT;
  assign w_req     = r_run && (r_state == FETCH || (r_state == MEM && (w_ld || w_st)));
  assign w_timeout = !bus.iMemReady && r_wait == WAIT_LAST;
  assign bus.oALU_op = w_r ? bus.iFunct : (w_ld || w_st) ? ALU_ADD : w_beq ? ALU_SUB : '0;
  assign bus.oHalt   = r_state == HALT;
  assign bus.oFault  = r_state == FAULT;
  // next state and strobes; r_run keeps everything quiet until the first edge out of reset
  always_comb begin
    w_next        = r_state;
    bus.oIR_en    = 1'b0;
    bus.oMDR_en   = 1'b0;
    bus.oRF_Write = 1'b0;
    bus.oPC_en    = 1'b0;
    bus.oMemRead  = 1'b0;
    bus.oMemWrite = 1'b0;
    bus.oAddrSel  = 1'b0;
    if (r_run) begin
      case (r_state)
        FETCH: begin
          bus.oMemRead = 1'b1;
          bus.oIR_en   = bus.iMemReady;
          bus.oPC_en   = bus.iMemReady;
          w_next       = bus.iMemReady ? DECODE : w_timeout ? FAULT : FETCH;
        end
        DECODE: w_next = (w_r || w_ld || w_st || w_beq) ? EXEC : w_hlt ? HALT : FAULT;
        EXEC: begin
          bus.oPC_en = w_beq && bus.iAluZero;
          w_next     = w_r ? WB : (w_ld || w_st) ? MEM : w_beq ? FETCH : FAULT;
        end
        MEM: begin
          bus.oAddrSel  = 1'b1;
          bus.oMemRead  = w_ld;
          bus.oMemWrite = w_st;
          bus.oMDR_en   = w_ld && bus.iMemReady;
          w_next        = !(w_ld || w_st) ? FAULT : bus.iMemReady ? (w_ld ? WB : FETCH) : w_timeout ? FAULT : MEM;
        end
        WB: begin
          bus.oRF_Write = 1'b1;
          w_next        = FETCH;
        end
        default: w_next = r_state;
      endcase
    end
  end
  // state, run flag and wait counter; the counter only survives while a request is stalled
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_state <= FETCH;
      r_run   <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
      r_wait  <= (w_req && !bus.iMemReady) ? r_wait + 8'd1 : '0;
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: replays per-cycle expected output traces built from the instruction-level behaviour
module tb_mc_ctrl;
  localparam int TO = 4;
  localparam int IR = 8, MDR = 7, RF = 6, PC = 5, MR = 4, MW = 3, AS = 2, HL = 1, FL = 0;
  typedef struct {
    logic [8:0] o;
    logic       rdy;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       ca;
    logic [5:0] alu;
  } step_t;
  logic  clk = 1'b0;
  logic  nRst = 1'b0;
  int    errors = 0;
  int    checks = 0;
  string tag = "init";
  step_t q[$];
  mc_ctrl_if #(.OP_W(6)) bus();
  mc_ctrl #(.OP_W(6), .MEM_TIMEOUT(TO)) dut (.iClk(clk), .nRst(nRst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [8:0] bv(input int b);
    return 9'd1 << b;
  endfunction

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic logic [8:0] obs();
    return {bus.oIR_en, bus.oMDR_en, bus.oRF_Write, bus.oPC_en, bus.oMemRead,
            bus.oMemWrite, bus.oAddrSel, bus.oHalt, bus.oFault};
  endfunction

  function automatic void push(input logic [8:0] o, input logic rdy, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic ca, input logic [5:0] alu);
    q.push_back('{o, rdy, op, fn, z, ca, alu});
  endfunction

  // expected trace of one complete instruction: fetch waits, fetch, decode, exec, optional mem and wb
  task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int fw, input int mw);
    logic ld, st, bq;
    logic [5:0] alu;
    logic [8:0] acc;
    ld  = op == 6'h23;
    st  = op == 6'h2B;
    bq  = op == 6'h04;
    alu = op == 6'h00 ? fn : (ld || st) ? 6'h20 : bq ? 6'h22 : 6'h00;
    for (int i = 0; i < fw; i++) push(bv(MR), 1'b0, op, fn, rnd(), 1'b0, 6'h0);
    push(bv(MR) | bv(IR) | bv(PC), 1'b1, op, fn, rnd(), 1'b0, 6'h0);
    push(9'd0, rnd(), op, fn, rnd(), 1'b0, 6'h0);
    push((z && bq) ? bv(PC) : 9'd0, rnd(), op, fn, z, 1'b1, alu);
    if (ld || st) begin
      acc = bv(AS) | bv(ld ? MR : MW);
      for (int i = 0; i < mw; i++) push(acc, 1'b0, op, fn, rnd(), 1'b0, 6'h0);
      push(acc | (ld ? bv(MDR) : 9'd0), 1'b1, op, fn, rnd(), 1'b0, 6'h0);
    end
    if (!bq && !st) push(bv(RF), rnd(), op, fn, rnd(), 1'b0, 6'h0);
  endtask

  // drive each step on the falling edge and compare the combinational outputs 1 ns later
  task automatic play();
    step_t s;
    logic [8:0] o;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      bus.iOpcode   = s.op;
      bus.iFunct    = s.fn;
      bus.iAluZero  = s.z;
      bus.iMemReady = s.rdy;
      #1;
      o = obs();
      checks++;
      if (o !== s.o) begin
        errors++;
        $display("FAIL %s outputs{IR,MDR,RF,PC,MR,MW,AS,HL,FL}: got %b expected %b", tag, o, s.o);
      end
      if (s.ca) begin
        checks++;
        if (bus.oALU_op !== s.alu) begin
          errors++;
          $display("FAIL %s alu_op: got %h expected %h", tag, bus.oALU_op, s.alu);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRst = 1'b0;
    bus.iMemReady = 1'b1;
    #1;
    checks++;
    if (obs() !== 9'd0) begin
      errors++;
      $display("FAIL %s reset_assert: got %b expected 0", tag, obs());
    end
    @(negedge clk);
    nRst = 1'b1;
    #1;
    checks++;
    if (obs() !== 9'd0) begin
      errors++;
      $display("FAIL %s reset_release: got %b expected 0", tag, obs());
    end
  endtask

  task automatic test_reset();
    tag = "reset";
    bus.iOpcode   = 6'h00;
    bus.iFunct    = 6'h00;
    bus.iAluZero  = 1'b0;
    bus.iMemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.iMemReady = rnd();
      #1;
      checks++;
      if (obs() !== 9'd0) begin
        errors++;
        $display("FAIL %s held_in_reset: got %b expected 0", tag, obs());
      end
    end
    do_reset();
  endtask

  task automatic test_rtype();
    tag = "rtype";
    gen_instr(6'h00, 6'h24, rnd(), 0, 0);
    for (int i = 0; i < 3; i++) gen_instr(6'h00, 6'($urandom), rnd(), $urandom_range(0, TO - 1), 0);
    play();
  endtask

  task automatic test_load();
    tag = "load";
    gen_instr(6'h23, 6'($urandom), rnd(), 0, 3);
    gen_instr(6'h23, 6'($urandom), rnd(), TO - 1, TO - 1);
    play();
  endtask

  task automatic test_store();
    tag = "store";
    gen_instr(6'h2B, 6'($urandom), rnd(), 0, 0);
    gen_instr(6'h2B, 6'($urandom), rnd(), $urandom_range(0, TO - 1), TO - 1);
    play();
  endtask

  task automatic test_beq();
    tag = "beq";
    gen_instr(6'h04, 6'($urandom), 1'b1, 0, 0);
    gen_instr(6'h04, 6'($urandom), 1'b0, 0, 0);
    play();
  endtask

  task automatic test_random();
    logic [5:0] ops [4];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04};
    tag = "random";
    for (int i = 0; i < 30; i++)
      gen_instr(ops[$urandom_range(0, 3)], 6'($urandom), rnd(), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
    play();
  endtask

  task automatic test_halt();
    tag = "halt";
    push(bv(MR) | bv(IR) | bv(PC), 1'b1, 6'h3F, 6'h0, rnd(), 1'b0, 6'h0);
    push(9'd0, rnd(), 6'h3F, 6'h0, rnd(), 1'b0, 6'h0);
    for (int i = 0; i < 6; i++) push(bv(HL), rnd(), 6'($urandom), 6'($urandom), rnd(), 1'b0, 6'h0);
    play();
    @(negedge clk);
    nRst = 1'b0;
    #1;
    checks++;
    if (obs() !== 9'd0) begin
      errors++;
      $display("FAIL %s halt_cleared: got %b expected 0", tag, obs());
    end
    @(negedge clk);
    nRst = 1'b1;
    gen_instr(6'h00, 6'($urandom), rnd(), 0, 0);
    play();
  endtask

  task automatic test_bad_opcode();
    logic [5:0] op;
    tag = "bad_opcode";
    do op = 6'($urandom); while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h3F);
    push(bv(MR) | bv(IR) | bv(PC), 1'b1, op, 6'h0, rnd(), 1'b0, 6'h0);
    push(9'd0, rnd(), op, 6'h0, rnd(), 1'b0, 6'h0);
    for (int i = 0; i < 4; i++) push(bv(FL), rnd(), 6'($urandom), 6'($urandom), rnd(), 1'b0, 6'h0);
    play();
    do_reset();
  endtask

  task automatic test_timeout();
    tag = "fetch_timeout";
    for (int i = 0; i < TO; i++) push(bv(MR), 1'b0, 6'($urandom), 6'h0, rnd(), 1'b0, 6'h0);
    for (int i = 0; i < 5; i++) push(bv(FL), rnd(), 6'($urandom), 6'h0, rnd(), 1'b0, 6'h0);
    play();
    do_reset();
    tag = "mem_timeout";
    push(bv(MR) | bv(IR) | bv(PC), 1'b1, 6'h2B, 6'h0, rnd(), 1'b0, 6'h0);
    push(9'd0, rnd(), 6'h2B, 6'h0, rnd(), 1'b0, 6'h0);
    push(9'd0, rnd(), 6'h2B, 6'h0, rnd(), 1'b1, 6'h20);
    for (int i = 0; i < TO; i++) push(bv(AS) | bv(MW), 1'b0, 6'h2B, 6'h0, rnd(), 1'b0, 6'h0);
    for (int i = 0; i < 3; i++) push(bv(FL), rnd(), 6'h2B, 6'h0, rnd(), 1'b0, 6'h0);
    play();
    do_reset();
  endtask

  task automatic test_store_reset();
    tag = "store_reset";
    push(bv(MR) | bv(IR) | bv(PC), 1'b1, 6'h2B, 6'h0, rnd(), 1'b0, 6'h0);
    push(9'd0, rnd(), 6'h2B, 6'h0, rnd(), 1'b0, 6'h0);
    push(9'd0, rnd(), 6'h2B, 6'h0, rnd(), 1'b1, 6'h20);
    push(bv(AS) | bv(MW), 1'b0, 6'h2B, 6'h0, rnd(), 1'b0, 6'h0);
    play();
    #1;
    nRst = 1'b0;
    #1;
    checks++;
    if (obs() !== 9'd0) begin
      errors++;
      $display("FAIL %s async_drop: got %b expected 0", tag, obs());
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.iMemReady = 1'b1;
      #1;
      checks++;
      if (obs() !== 9'd0) begin
        errors++;
        $display("FAIL %s no_wb_in_reset: got %b expected 0", tag, obs());
      end
    end
    @(negedge clk);
    nRst = 1'b1;
    gen_instr(6'h00, 6'($urandom), rnd(), 0, 0);
    play();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_store();
    test_beq();
    test_random();
    test_halt();
    test_bad_opcode();
    test_timeout();
    test_store_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
